// File: rtl/soc_boot_ctrl.sv
// Boot-and-run controller: streams a program image into instruction memory over
// a valid/ready port, releases the core, and stops it on ebreak or cycle timeout.
module soc_boot_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic                  abort_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  imem_wen_o,
    output logic [ADDR_WIDTH-1:0] imem_waddr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    input  logic                  ebreak_i,
    output logic                  core_rstn_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam logic [ADDR_WIDTH:0]  LP_DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]  LP_WCNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LP_LAST_CYCLE = CNT_WIDTH'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_wcnt;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_core_rstn;
    logic                  r_done;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_cycle_cnt;

    logic                  w_start;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_timeout_hit;
    logic [ADDR_WIDTH:0]   w_len_clamped;

    // Oversized requests load the whole memory rather than wrapping the address.
    assign w_len_clamped = (load_len_i > LP_DEPTH) ? LP_DEPTH : load_len_i;
    assign w_timeout_hit = (MAX_CYCLES > 0) && (r_cycle_cnt == LP_LAST_CYCLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_next_state = r_state;
        w_start      = 1'b0;
        w_hs         = 1'b0;
        w_last       = (r_wcnt == r_len - LP_WCNT_ONE);
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (load_start_i) begin
                    w_start      = 1'b1;
                    w_next_state = (w_len_clamped == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid_i) begin
                    w_hs = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: w_next_state = ST_RUN;
            ST_RUN: begin
                if (ebreak_i || w_timeout_hit) begin
                    w_next_state = ST_HALT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (abort_i) begin
            w_next_state = ST_IDLE;
            w_start      = 1'b0;
            w_hs         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len       <= '0;
            r_wcnt      <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_core_rstn <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments below override earlier ones.
            r_wen       <= w_hs;
            r_core_rstn <= (w_next_state == ST_RUN);
            if (w_hs) begin
                r_waddr <= r_wcnt[ADDR_WIDTH-1:0];
                r_wdata <= load_data_i;
                r_wcnt  <= r_wcnt + LP_WCNT_ONE;
            end
            if (abort_i) begin
                r_wcnt      <= '0;
                r_cycle_cnt <= '0;
                r_done      <= 1'b0;
                r_timeout   <= 1'b0;
            end else if (w_start) begin
                r_len       <= w_len_clamped;
                r_wcnt      <= '0;
                r_cycle_cnt <= '0;
                r_done      <= 1'b0;
                r_timeout   <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (r_cycle_cnt != '1) begin
                    r_cycle_cnt <= r_cycle_cnt + LP_CNT_ONE;
                end
                // ebreak takes precedence when it lands on the timeout cycle.
                if (ebreak_i) begin
                    r_done <= 1'b1;
                end else if (w_timeout_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign load_ready_o = (r_state == ST_LOAD);
    assign busy_o       = (r_state == ST_LOAD) || (r_state == ST_DRAIN) || (r_state == ST_RUN);
    assign imem_wen_o   = r_wen;
    assign imem_waddr_o = r_waddr;
    assign imem_wdata_o = r_wdata;
    assign core_rstn_o  = r_core_rstn;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
    assign cycle_cnt_o  = r_cycle_cnt;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Bench for soc_boot_ctrl: two instances (no timeout with a narrow saturating
// counter, and MAX_CYCLES=16) share stimulus and are checked against a model.
module tb_soc_boot_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          abort_in;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          ebreak;

    logic          d0_ready, d0_wen, d0_rstn, d0_busy, d0_done, d0_to;
    logic [AW-1:0] d0_waddr;
    logic [DW-1:0] d0_wdata;
    logic [3:0]    d0_cnt;
    logic          d1_ready, d1_wen, d1_rstn, d1_busy, d1_done, d1_to;
    logic [AW-1:0] d1_waddr;
    logic [DW-1:0] d1_wdata;
    logic [7:0]    d1_cnt;

    soc_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4), .MAX_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .load_len_i(load_len),
        .abort_i(abort_in), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(d0_ready), .imem_wen_o(d0_wen), .imem_waddr_o(d0_waddr),
        .imem_wdata_o(d0_wdata), .ebreak_i(ebreak), .core_rstn_o(d0_rstn),
        .busy_o(d0_busy), .done_o(d0_done), .timeout_o(d0_to), .cycle_cnt_o(d0_cnt)
    );

    soc_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(8), .MAX_CYCLES(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .load_len_i(load_len),
        .abort_i(abort_in), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(d1_ready), .imem_wen_o(d1_wen), .imem_waddr_o(d1_waddr),
        .imem_wdata_o(d1_wdata), .ebreak_i(ebreak), .core_rstn_o(d1_rstn),
        .busy_o(d1_busy), .done_o(d1_done), .timeout_o(d1_to), .cycle_cnt_o(d1_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[dut%0d] at %0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic both(input string nm, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] exp);
        check(nm, 0, a0, exp);
        check(nm, 1, a1, exp);
    endtask

    // Behavioural model: phase plus counters, updated once per clock edge.
    typedef enum int {P_IDLE, P_LOAD, P_DRAIN, P_RUN, P_HALT} phase_t;
    phase_t        m_ph    [2];
    int            m_len   [2];
    int            m_next  [2];
    int            m_cnt   [2];
    bit            m_done  [2];
    bit            m_to    [2];
    bit            m_wen   [2];
    int            m_waddr [2];
    logic [DW-1:0] m_wdata [2];

    function automatic int cnt_cap(input int i);
        return (i == 0) ? 15 : 255;
    endfunction

    function automatic int max_cycles(input int i);
        return (i == 0) ? 0 : 16;
    endfunction

    task automatic model_reset(input int i);
        m_ph[i] = P_IDLE; m_len[i] = 0; m_next[i] = 0; m_cnt[i] = 0;
        m_done[i] = 1'b0; m_to[i] = 1'b0; m_wen[i] = 1'b0; m_waddr[i] = 0; m_wdata[i] = '0;
    endtask

    task automatic model_step(input int i);
        m_wen[i] = 1'b0;
        if (abort_in) begin
            m_ph[i] = P_IDLE; m_next[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0; m_to[i] = 1'b0;
        end else begin
            case (m_ph[i])
                P_IDLE, P_HALT: begin
                    if (load_start) begin
                        m_len[i]  = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                        m_next[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0; m_to[i] = 1'b0;
                        m_ph[i]   = (m_len[i] == 0) ? P_RUN : P_LOAD;
                    end
                end
                P_LOAD: begin
                    if (load_valid) begin
                        m_wen[i] = 1'b1; m_waddr[i] = m_next[i]; m_wdata[i] = load_data;
                        m_next[i]++;
                        if (m_next[i] == m_len[i]) m_ph[i] = P_DRAIN;
                    end
                end
                P_DRAIN: m_ph[i] = P_RUN;
                P_RUN: begin
                    if (m_cnt[i] < cnt_cap(i)) m_cnt[i]++;
                    if (ebreak) begin
                        m_done[i] = 1'b1; m_ph[i] = P_HALT;
                    end else if (max_cycles(i) != 0 && m_cnt[i] == max_cycles(i)) begin
                        m_to[i] = 1'b1; m_ph[i] = P_HALT;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_step(i);
        end
    end

    task automatic compare_inst(input int i, input logic ready, input logic wen, input logic [AW-1:0] waddr,
                                input logic [DW-1:0] wdata, input logic rstn, input logic busy,
                                input logic done, input logic to, input logic [31:0] cnt);
        check("ready", i, 32'(ready), 32'(m_ph[i] == P_LOAD));
        check("wen", i, 32'(wen), 32'(m_wen[i]));
        if (m_wen[i]) begin
            check("waddr", i, 32'(waddr), m_waddr[i]);
            check("wdata", i, wdata, m_wdata[i]);
        end
        check("core_rstn", i, 32'(rstn), 32'(m_ph[i] == P_RUN));
        check("busy", i, 32'(busy), 32'(m_ph[i] == P_LOAD || m_ph[i] == P_DRAIN || m_ph[i] == P_RUN));
        check("done", i, 32'(done), 32'(m_done[i]));
        check("timeout", i, 32'(to), 32'(m_to[i]));
        check("cycle_cnt", i, cnt, m_cnt[i]);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            compare_inst(0, d0_ready, d0_wen, d0_waddr, d0_wdata, d0_rstn, d0_busy, d0_done, d0_to, 32'(d0_cnt));
            compare_inst(1, d1_ready, d1_wen, d1_waddr, d1_wdata, d1_rstn, d1_busy, d1_done, d1_to, 32'(d1_cnt));
        end
    end

    // Memory scoreboard: captures what each instance actually commits.
    logic [DW-1:0] sb_mem    [2][DEPTH];
    int            sb_writes [2];
    int            sb_first  [2];
    int            sb_last   [2];

    task automatic sb_record(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (sb_writes[i] == 0) sb_first[i] = int'(a);
        sb_last[i]   = int'(a);
        sb_mem[i][a] = d;
        sb_writes[i]++;
    endtask

    task automatic sb_mark();
        for (int i = 0; i < 2; i++) begin
            sb_writes[i] = 0; sb_first[i] = -1; sb_last[i] = -1;
        end
    endtask

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (d0_wen === 1'b1) sb_record(0, d0_waddr, d0_wdata);
            if (d1_wen === 1'b1) sb_record(1, d1_waddr, d1_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len);
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    logic [DW-1:0] img3 [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0010_0073};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int idx;
        int nbad;
        rst = 1'b1; load_start = 1'b0; load_len = '0; abort_in = 1'b0;
        load_valid = 1'b0; load_data = '0; ebreak = 1'b0;
        sb_mark();
        repeat (3) @(posedge clk);
        #2;
        both("rst_core_rstn", 32'(d0_rstn), 32'(d1_rstn), 0);
        both("rst_ready", 32'(d0_ready), 32'(d1_ready), 0);
        both("rst_wen", 32'(d0_wen), 32'(d1_wen), 0);
        both("rst_waddr", 32'(d0_waddr), 32'(d1_waddr), 0);
        both("rst_wdata", d0_wdata, d1_wdata, 0);
        both("rst_busy", 32'(d0_busy), 32'(d1_busy), 0);
        both("rst_done", 32'(d0_done), 32'(d1_done), 0);
        both("rst_timeout", 32'(d0_to), 32'(d1_to), 0);
        both("rst_cnt", 32'(d0_cnt), 32'(d1_cnt), 0);
        rst = 1'b0;
        tick();

        // Three-word image, no bubbles, ebreak in the 5th RUN cycle.
        sb_mark();
        pulse_start(3);
        both("t1_ready_after_start", 32'(d0_ready), 32'(d1_ready), 1);
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1; load_data = img3[k]; tick();
        end
        load_valid = 1'b0;
        both("t1_drain_rstn", 32'(d0_rstn), 32'(d1_rstn), 0);
        both("t1_last_waddr", 32'(d0_waddr), 32'(d1_waddr), 2);
        both("t1_last_wdata", d0_wdata, d1_wdata, 32'h0010_0073);
        tick();
        both("t1_release", 32'(d0_rstn), 32'(d1_rstn), 1);
        repeat (4) tick();
        ebreak = 1'b1; tick(); ebreak = 1'b0;
        both("t1_done", 32'(d0_done), 32'(d1_done), 1);
        both("t1_timeout", 32'(d0_to), 32'(d1_to), 0);
        both("t1_cnt", 32'(d0_cnt), 32'(d1_cnt), 5);
        both("t1_halt_rstn", 32'(d0_rstn), 32'(d1_rstn), 0);
        for (int i = 0; i < 2; i++) begin
            check("t1_writes", i, sb_writes[i], 3);
            for (int k = 0; k < 3; k++) check("t1_mem", i, sb_mem[i][k], img3[k]);
        end

        // Four words with valid toggling 1,0,0,1,...
        sb_mark();
        pulse_start(4);
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            load_valid = (k % 3 == 0);
            load_data  = load_valid ? 32'hC0DE_0000 + DW'(idx) : 32'hBAD0_0000 + DW'(k);
            tick();
            if (load_valid) idx++;
        end
        load_valid = 1'b0;
        both("t2_drain_ready", 32'(d0_ready), 32'(d1_ready), 0);
        both("t2_drain_busy", 32'(d0_busy), 32'(d1_busy), 1);
        both("t2_drain_rstn", 32'(d0_rstn), 32'(d1_rstn), 0);
        tick();
        both("t2_run_after_one_drain", 32'(d0_rstn), 32'(d1_rstn), 1);
        for (int i = 0; i < 2; i++) begin
            check("t2_writes", i, sb_writes[i], 4);
            check("t2_first_addr", i, sb_first[i], 0);
            check("t2_last_addr", i, sb_last[i], 3);
            for (int k = 0; k < 4; k++) check("t2_mem", i, sb_mem[i][k], 32'hC0DE_0000 + DW'(k));
        end
        tick();
        ebreak = 1'b1; tick(); ebreak = 1'b0;
        both("t2_cnt", 32'(d0_cnt), 32'(d1_cnt), 2);

        // len=0 run with no ebreak: timeout on the 16th cycle for the limited instance.
        sb_mark();
        pulse_start(0);
        both("t3_len0_release", 32'(d0_rstn), 32'(d1_rstn), 1);
        repeat (16) tick();
        check("t3_timeout", 1, 32'(d1_to), 1);
        check("t3_done", 1, 32'(d1_done), 0);
        check("t3_cnt", 1, 32'(d1_cnt), 16);
        check("t3_halt_rstn", 1, 32'(d1_rstn), 0);
        check("t3_cnt_saturated", 0, 32'(d0_cnt), 15);
        check("t3_still_running", 0, 32'(d0_rstn), 1);
        ebreak = 1'b1; tick(); ebreak = 1'b0;
        check("t3_sat_done", 0, 32'(d0_done), 1);
        check("t3_sat_cnt_held", 0, 32'(d0_cnt), 15);
        check("t3_halt_ignores_ebreak", 1, 32'(d1_done), 0);
        both("t3_no_writes", sb_writes[0], sb_writes[1], 0);

        // ebreak on the 16th cycle beats the timeout.
        pulse_start(0);
        repeat (15) tick();
        ebreak = 1'b1; tick(); ebreak = 1'b0;
        check("t3b_done", 1, 32'(d1_done), 1);
        check("t3b_timeout", 1, 32'(d1_to), 0);
        check("t3b_cnt", 1, 32'(d1_cnt), 16);

        // Oversized length clamps to the memory depth.
        sb_mark();
        pulse_start(DEPTH + 5);
        load_valid = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            load_data = 32'hA500_0000 + DW'(k); tick();
        end
        load_valid = 1'b0;
        both("t4_running", 32'(d0_rstn), 32'(d1_rstn), 1);
        for (int i = 0; i < 2; i++) begin
            check("t4_writes", i, sb_writes[i], DEPTH);
            check("t4_first_addr", i, sb_first[i], 0);
            check("t4_last_addr", i, sb_last[i], DEPTH - 1);
            nbad = 0;
            for (int k = 0; k < DEPTH; k++) if (sb_mem[i][k] !== 32'hA500_0000 + DW'(k)) nbad++;
            check("t4_image_bad_words", i, nbad, 0);
        end
        ebreak = 1'b1; tick(); ebreak = 1'b0;

        // Abort after two of six words, then a fresh load restarts at address 0.
        sb_mark();
        pulse_start(6);
        for (int k = 0; k < 2; k++) begin
            load_valid = 1'b1; load_data = 32'h5500_0000 + DW'(k); tick();
        end
        abort_in = 1'b1; load_data = 32'h5500_0002; tick();
        abort_in = 1'b0; load_valid = 1'b0;
        both("t5_ready", 32'(d0_ready), 32'(d1_ready), 0);
        both("t5_busy", 32'(d0_busy), 32'(d1_busy), 0);
        both("t5_wen", 32'(d0_wen), 32'(d1_wen), 0);
        both("t5_writes", sb_writes[0], sb_writes[1], 2);
        repeat (2) tick();
        both("t5_core_held", 32'(d0_rstn), 32'(d1_rstn), 0);
        sb_mark();
        pulse_start(2);
        for (int k = 0; k < 2; k++) begin
            load_valid = 1'b1; load_data = 32'h6600_0000 + DW'(k); tick();
        end
        load_valid = 1'b0;
        tick();
        both("t5_restart_addr", sb_first[0], sb_first[1], 0);
        both("t5_restart_writes", sb_writes[0], sb_writes[1], 2);
        both("t5_restart_mem1", sb_mem[0][1], sb_mem[1][1], 32'h6600_0001);
        both("t5_release", 32'(d0_rstn), 32'(d1_rstn), 1);

        // Start during RUN is ignored; async reset mid-RUN clears everything at once.
        repeat (2) tick();
        pulse_start(3);
        both("t6_start_ignored_ready", 32'(d0_ready), 32'(d1_ready), 0);
        both("t6_start_ignored_rstn", 32'(d0_rstn), 32'(d1_rstn), 1);
        both("t6_cnt_before_rst", 32'(d0_cnt), 32'(d1_cnt), 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        both("t6_async_rstn", 32'(d0_rstn), 32'(d1_rstn), 0);
        both("t6_async_busy", 32'(d0_busy), 32'(d1_busy), 0);
        both("t6_async_cnt", 32'(d0_cnt), 32'(d1_cnt), 0);
        both("t6_async_done", 32'(d0_done), 32'(d1_done), 0);
        both("t6_async_timeout", 32'(d0_to), 32'(d1_to), 0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        tick();
        sb_mark();
        pulse_start(1);
        load_valid = 1'b1; load_data = 32'h7700_0001; tick();
        load_valid = 1'b0;
        tick();
        repeat (2) tick();
        ebreak = 1'b1; tick(); ebreak = 1'b0;
        both("t6_post_rst_done", 32'(d0_done), 32'(d1_done), 1);
        both("t6_post_rst_cnt", 32'(d0_cnt), 32'(d1_cnt), 3);
        both("t6_post_rst_writes", sb_writes[0], sb_writes[1], 1);
        both("t6_post_rst_mem0", sb_mem[0][0], sb_mem[1][0], 32'h7700_0001);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/soc_boot_ctrl.md
# soc_boot_ctrl

Parametrised boot-and-run controller that sits between the testbench/host and a CPU SoC. It streams a program image into instruction memory over a valid/ready port, holds the core in reset until loading completes, then releases it. It counts execution cycles and stops the core on ebreak or on a cycle timeout. It replaces ad-hoc direct instruction-memory writes with a handshaked, self-addressing loader and adds run control and status.

## Interface
- ADDR_WIDTH, 12, instruction-memory word-address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 32, instruction word width
- CNT_WIDTH, 32, cycle counter width
- MAX_CYCLES, 0, run-cycle limit; 0 disables timeout

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- load_start_i  in  1  start pulse; sampled only in IDLE or HALT
- load_len_i  in  ADDR_WIDTH+1  words to load, sampled with load_start_i
- abort_i  in  1  return to IDLE from any state
- load_valid_i  in  1  image word valid
- load_data_i  in  DATA_WIDTH  image word
- load_ready_o  out  1  loader accepts word
- imem_wen_o  out  1  instruction-memory write enable (registered)
- imem_waddr_o  out  ADDR_WIDTH  word address (registered)
- imem_wdata_o  out  DATA_WIDTH  write data (registered)
- ebreak_i  in  1  core ebreak indication
- core_rstn_o  out  1  active-low core reset (registered)
- busy_o  out  1  state is LOAD, DRAIN or RUN
- done_o  out  1  halted by ebreak
- timeout_o  out  1  halted by MAX_CYCLES
- cycle_cnt_o  out  CNT_WIDTH  RUN cycles elapsed

## Operation
- States: IDLE, LOAD, DRAIN, RUN, HALT.
- IDLE: core_rstn_o=0, load_ready_o=0.
  - On load_start_i with len>0: latch len, clear word counter, cycle_cnt, done and timeout; go to LOAD.
  - On load_start_i with len=0: clear the same flags; go directly to RUN and execute the existing image.
- Lengths above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH. The word address never wraps.
- LOAD: load_ready_o=1.
  - Each valid&ready cycle registers imem_wen_o=1, imem_waddr_o=word counter and imem_wdata_o=load_data_i; the counter then increments.
  - Cycles without valid register imem_wen_o=0. Bubbles of any length are legal.
  - On the handshake of the last word, go to DRAIN.
- DRAIN: one cycle. load_ready_o=0. The last registered write commits to memory on this cycle's edge. Next state is RUN.
- RUN: core_rstn_o=1.
  - cycle_cnt increments once per RUN cycle. It saturates at all-ones when MAX_CYCLES=0.
  - ebreak_i=1 goes to HALT with done_o=1.
  - Otherwise, cycle_cnt reaching MAX_CYCLES-1 while still in RUN (i.e. the MAX_CYCLES-th RUN cycle) goes to HALT with timeout_o=1.
  - Simultaneous ebreak and timeout: ebreak wins (done_o=1, timeout_o=0).
- HALT: core_rstn_o=0. cycle_cnt, done_o and timeout_o are held. load_start_i restarts exactly as from IDLE.
- abort_i in any state: next state IDLE, core_rstn_o=0, imem_wen_o=0, word counter cleared, cycle_cnt cleared, done/timeout cleared. abort_i has priority over every other event.
- load_start_i is ignored in LOAD, DRAIN and RUN.

## Timing
- Reset values: state IDLE, core_rstn_o=0, load_ready_o=0, imem_wen_o=0, imem_waddr_o=0, imem_wdata_o=0, busy_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronously). Any in-flight load is discarded.
- load_ready_o is a decode of state (Moore). It rises the cycle after load_start_i.
- Write latency: handshake at edge k means imem_wen_o is high during cycle k..k+1 and the memory write occurs at edge k+1.
- Core release: core_rstn_o rises at the edge leaving DRAIN. For len=0 it rises at the edge leaving IDLE.
- cycle_cnt_o counts the ebreak cycle. If ebreak_i is sampled in the N-th RUN cycle, cycle_cnt_o=N in HALT.
- done_o, timeout_o and core_rstn_o=0 all appear at the edge following the halting event.
- Minimum turnaround: len=L with no bubbles gives L+2 cycles from load_start_i to core_rstn_o=1.

## Test plan
- Load 3 words (0x00000013, 0x00100093, 0x00100073) with no bubbles, then ebreak_i pulsed in the 5th RUN cycle -> imem writes to addresses 0,1,2; core_rstn_o high 5 cycles after start; done_o=1, cycle_cnt_o=5, core_rstn_o=0.
- Load 4 words with load_valid_i toggling 1,0,0,1,... -> addresses 0..3 written in order with no duplicates; imem_wen_o low during bubbles; DRAIN lasts exactly one cycle.
- MAX_CYCLES=16, ebreak_i never asserted -> timeout_o=1, done_o=0, cycle_cnt_o=16. Repeat with ebreak_i on the 16th cycle -> done_o=1, timeout_o=0.
- load_len_i=0 -> no imem writes; core_rstn_o high one cycle after start. Set load_len_i=2^ADDR_WIDTH+5 -> exactly 2^ADDR_WIDTH writes; last address is all-ones.
- abort_i after 2 of 6 words -> IDLE next cycle; load_ready_o=0; core stays in reset. A new load_start_i restarts at address 0.
- rst_i asserted mid-RUN, asynchronously between edges -> core_rstn_o and all status outputs clear immediately; load_start_i after deassertion works normally; load_start_i pulsed during RUN is ignored.
